// File: rtl/abs_diff_err_eval_pkg.sv
// Shared definitions for the |A-B| error evaluator: FSM states, operand and
// accumulator widths, and a small magnitude-distance helper.
package abs_diff_err_eval_pkg;

    localparam int unsigned OP_W      = 4;          // operand width
    localparam int unsigned PI_W      = 2 * OP_W;   // packed stimulus width {B, A}
    localparam int unsigned VEC_COUNT = 256;        // exhaustive sweep length
    localparam int unsigned IDX_W     = 9;          // vector index width
    localparam int unsigned CNT_W     = 9;          // error counter width (max 256)
    localparam int unsigned SUM_W     = 12;         // error sum width (max 3840)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Unsigned distance between two operand-width values.
    function automatic logic [OP_W-1:0] abs_dist(
        input logic [OP_W-1:0] x,
        input logic [OP_W-1:0] y
    );
        logic [OP_W-1:0] r;
        if (x >= y) begin
            r = x - y;
        end else begin
            r = y - x;
        end
        return r;
    endfunction

endpackage

// File: rtl/abs_diff_err_eval_exact.sv
// Golden |A-B| model for 4-bit operands. Purely combinational so other error
// evaluators can reuse it as a reference next to their own circuit under test.
module abs_diff_exact
    import abs_diff_err_eval_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] y
);

    logic signed [OP_W:0] diff_s;
    logic signed [OP_W:0] mag_s;

    // Signed difference on one extra bit, then fold negative results back.
    always_comb begin
        diff_s = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff_s < 5'sd0) begin
            mag_s = -diff_s;
        end else begin
            mag_s = diff_s;
        end
        y = mag_s[OP_W-1:0];
    end

endmodule

// File: rtl/abs_diff_err_eval.sv
// Exhaustive error evaluator for an external |A-B| circuit. Drives all 256
// operand pairs one per cycle, compares the returned result one cycle later
// against the golden model, and accumulates error count, maximum and sum.
module abs_diff_err_eval
    import abs_diff_err_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [PI_W-1:0]  dut_pi,
    input  logic [OP_W-1:0]  dut_po,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [OP_W-1:0]  max_err,
    output logic [SUM_W-1:0] sum_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PI_W-1:0]  dut_pi_q, dut_pi_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [OP_W-1:0]  max_err_q, max_err_d;
    logic [SUM_W-1:0] sum_err_q, sum_err_d;

    logic [OP_W-1:0]  exact_s;
    logic [OP_W-1:0]  err_s;

    // dut_pi_q doubles as the registered copy of the vector whose result is
    // on dut_po this cycle; valid_q marks that such a vector is pending.
    abs_diff_exact u_exact (
        .a (dut_pi_q[OP_W-1:0]),
        .b (dut_pi_q[PI_W-1:OP_W]),
        .y (exact_s)
    );

    // Per-vector error magnitude between golden and observed result.
    always_comb begin
        err_s = abs_dist(exact_s, dut_po);
    end

    // Next-state, stimulus sequencing and accumulator update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dut_pi_d    = dut_pi_q;
        valid_d     = 1'b0;
        err_count_d = err_count_q;
        max_err_d   = max_err_q;
        sum_err_d   = sum_err_q;

        // Fold in the result of the vector applied last cycle.
        if (valid_q) begin
            if (err_s != 4'd0) begin
                err_count_d = err_count_q + 9'd1;
            end else begin
                err_count_d = err_count_q;
            end
            sum_err_d = sum_err_q + SUM_W'(err_s);
            if (err_s > max_err_q) begin
                max_err_d = err_s;
            end else begin
                max_err_d = max_err_q;
            end
        end else begin
            err_count_d = err_count_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SWEEP;
                    idx_d       = '0;
                    dut_pi_d    = '0;
                    err_count_d = '0;
                    max_err_d   = '0;
                    sum_err_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            SWEEP: begin
                dut_pi_d = idx_q[PI_W-1:0];
                idx_d    = idx_q + 9'd1;
                valid_d  = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    state_d = SWEEP;
                end
            end
            DRAIN: begin
                // Last vector is compared here; nothing new is driven.
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SWEEP) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dut_pi_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            max_err_q   <= '0;
            sum_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dut_pi_q    <= dut_pi_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            max_err_q   <= max_err_d;
            sum_err_q   <= sum_err_d;
        end
    end

    assign dut_pi    = dut_pi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign max_err   = max_err_q;
    assign sum_err   = sum_err_q;

endmodule

// File: tb/tb_abs_diff_err_eval.sv
// Bench for abs_diff_err_eval: a behavioural circuit under test with several
// fault modes, and a reference model that recomputes the expected statistics
// over the full 256-vector operand space.
module tb_abs_diff_err_eval;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  dut_pi;
    logic [3:0]  dut_po;
    logic        busy;
    logic        done;
    logic [8:0]  err_count;
    logic [3:0]  max_err;
    logic [11:0] sum_err;

    int          mode;          // 0 exact, 1 zero, 2 exact^1, 3 random table
    logic [3:0]  rand_tbl [256];
    int          n_vec;
    int          n_miss;

    abs_diff_err_eval u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_pi    (dut_pi),
        .dut_po    (dut_po),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .max_err   (max_err),
        .sum_err   (sum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain-arithmetic |A-B| for a packed vector value.
    function automatic int ref_exact(input int v);
        int a;
        int b;
        a = v % 16;
        b = v / 16;
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // What the behavioural circuit under test returns for vector v in mode m.
    function automatic int ref_po(input int m, input int v);
        case (m)
            0:       return ref_exact(v);
            1:       return 0;
            2:       return ref_exact(v) ^ 1;
            default: return int'(rand_tbl[v]);
        endcase
    endfunction

    // Behavioural circuit under test, combinational from dut_pi.
    always_comb begin
        dut_po = 4'(ref_po(mode, int'(dut_pi)));
    end

    // Expected statistics over the whole operand space.
    function automatic void ref_stats(input int m, output int cnt, output int mx, output int sm);
        int e;
        cnt = 0;
        mx  = 0;
        sm  = 0;
        for (int v = 0; v < 256; v++) begin
            e = ref_exact(v) - ref_po(m, v);
            if (e < 0) e = -e;
            if (e != 0) cnt++;
            if (e > mx) mx = e;
            sm += e;
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;   // reset must win over start
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_flags: got busy=%0b done=%0b expected 0 0", busy, done);
        end
        n_vec++;
        if (err_count !== 9'd0 || max_err !== 4'd0 || sum_err !== 12'd0 || dut_pi !== 8'd0) begin
            n_miss++;
            $display("FAIL reset_values: got cnt=%0d max=%0d sum=%0d pi=%0d expected all 0",
                     err_count, max_err, sum_err, dut_pi);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_idle: got busy=%0b expected 0", busy);
        end
    endtask

    // One sweep: optional start pulses while busy, optional reset at a vector.
    task automatic test_sweep(input int m, input bit pulse, input int abort_at, input string tag);
        int cnt;
        int mx;
        int sm;
        int bc;
        ref_stats(m, cnt, mx, sm);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== 9'd0 || max_err !== 4'd0 || sum_err !== 12'd0) begin
            n_miss++;
            $display("FAIL %s_enter: got busy=%0b done=%0b cnt=%0d max=%0d sum=%0d expected 1 0 0 0 0",
                     tag, busy, done, err_count, max_err, sum_err);
        end
        bc = 0;
        while (busy === 1'b1 && bc < 400) begin
            if (bc >= 1) begin
                n_vec++;
                if (dut_pi !== 8'(bc - 1)) begin
                    n_miss++;
                    $display("FAIL %s_pi_seq: got %0d expected %0d", tag, dut_pi, bc - 1);
                end
            end
            if (abort_at >= 0 && bc == abort_at + 1) begin
                start = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                n_vec++;
                if (busy !== 1'b0 || done !== 1'b0 || err_count !== 9'd0 || max_err !== 4'd0
                    || sum_err !== 12'd0 || dut_pi !== 8'd0) begin
                    n_miss++;
                    $display("FAIL %s_abort: got busy=%0b done=%0b cnt=%0d max=%0d sum=%0d pi=%0d expected all 0",
                             tag, busy, done, err_count, max_err, sum_err, dut_pi);
                end
                return;
            end
            start = pulse && (bc == 5 || bc == 200);
            @(negedge clk);
            bc++;
        end
        start = 1'b0;
        n_vec++;
        if (bc !== 257) begin
            n_miss++;
            $display("FAIL %s_busy_len: got %0d expected 257", tag, bc);
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_miss++;
            $display("FAIL %s_done: got %0b expected 1", tag, done);
        end
        n_vec++;
        if (err_count !== 9'(cnt) || max_err !== 4'(mx) || sum_err !== 12'(sm)) begin
            n_miss++;
            $display("FAIL %s_results: got cnt=%0d max=%0d sum=%0d expected %0d %0d %0d",
                     tag, err_count, max_err, sum_err, cnt, mx, sm);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || err_count !== 9'(cnt) || max_err !== 4'(mx)
            || sum_err !== 12'(sm) || dut_pi !== 8'd255) begin
            n_miss++;
            $display("FAIL %s_frozen: got done=%0b busy=%0b cnt=%0d max=%0d sum=%0d pi=%0d expected 1 0 %0d %0d %0d 255",
                     tag, done, busy, err_count, max_err, sum_err, dut_pi, cnt, mx, sm);
        end
    endtask

    task automatic test_exact();
        test_sweep(0, 1'b0, -1, "exact");
    endtask

    task automatic test_tied_zero();
        test_sweep(1, 1'b0, -1, "zero");
    endtask

    task automatic test_xor_lsb();
        test_sweep(2, 1'b0, -1, "xor1");
    endtask

    task automatic test_start_ignored();
        test_sweep(3, 1'b1, -1, "rand_pulse");
    endtask

    task automatic test_reset_mid_sweep();
        test_sweep(3, 1'b0, 100, "abort");
        test_sweep(3, 1'b0, -1, "after_abort");
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        mode   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rand_tbl[i] = 4'($urandom_range(0, 15));
            end else begin
                rand_tbl[i] = 4'(ref_exact(i));
            end
        end
        test_reset();
        test_exact();
        test_tied_zero();
        test_xor_lsb();
        test_start_ignored();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
